alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Execute-entry stage of the RISC-V pipeline that drives the ALU's operand and opcode inputs. It accepts a decoded instruction from ID over a valid/ready handshake and translates ALUOp/funct3/funct7 into the 4-bit ALU Operation code. It selects SrcA/SrcB, registers everything in one pipeline slot, and presents the result to the ALU with backpressure and flush support. It is the producer side of the ALU's SrcA/SrcB/Operation interface.

## Interface
- DATA_WIDTH, 32, operand width
- OPCODE_LENGTH, 4, ALU Operation width
- REG_ADDR_W, 5, destination register index width
---
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears the stage
- in_valid  in  1  ID presents an instruction
- in_ready  out  1  stage can accept this cycle
- alu_op  in  2  00 mem/addr, 01 branch, 10 R-type, 11 I-type ALU
- funct3  in  3  instruction funct3
- funct7_b5  in  1  instruction bit 30
- alu_src_a  in  1  0 = rs1_data, 1 = pc
- alu_src_b  in  1  0 = rs2_data, 1 = imm
- rs1_data, rs2_data, pc, imm  in  DATA_WIDTH  operand sources
- rd_in  in  REG_ADDR_W  destination register
- flush  in  1  kill the slot contents (branch mispredict)
- out_valid  out  1  slot holds an instruction for EX
- out_ready  in  1  EX consumes the slot this cycle
- SrcA, SrcB  out  DATA_WIDTH  ALU operands (signed)
- Operation  out  OPCODE_LENGTH  ALU opcode
- rd_out  out  REG_ADDR_W  registered rd_in
- illegal_op  out  1  registered decode-failure flag, qualified by out_valid

## Operation
- Opcodes: AND 0000, OR 0001, XOR 0010, ADD 0100, SUB 0101, EQ 1000, LT 1001, SLL 1100, SRL 1101, SRA 1110.
- alu_op 00: ADD regardless of funct3.
- alu_op 01: funct3 000/001 (BEQ/BNE) give EQ; 100/101 (BLT/BGE) give LT. The branch unit applies the inversion. Any other funct3 is illegal.
- alu_op 10 (R-type):
  - funct3 000: ADD, or SUB when funct7_b5 = 1.
  - 001 SLL; 010 LT; 100 XOR; 101 SRL, or SRA when funct7_b5 = 1; 110 OR; 111 AND.
  - 011 (SLTU) is illegal.
- alu_op 11 (I-type): same as R-type, except funct3 000 is always ADD (funct7_b5 ignored).
- For I-type shifts (funct3 001/101), SrcB = zero-extended imm[4:0]. Otherwise SrcB is selected by alu_src_b.
- SrcA is selected by alu_src_a. No width change; operands pass through unmodified.
- Illegal decode: Operation = 0000, illegal_op = 1, instruction still occupies the slot and flows out normally.

## Timing
- Reset values: out_valid 0, SrcA 0, SrcB 0, Operation 0000, rd_out 0, illegal_op 0.
- in_ready = !out_valid || out_ready. This is combinational and in_ready is 1 during reset.
- Accept on in_valid && in_ready. Outputs are updated next edge with out_valid = 1 (latency 1 cycle).
- Stall: while out_valid && !out_ready, all outputs are held bit-stable and in_ready = 0.
- Consume without new input: out_valid goes to 0 next edge. Data outputs keep their last value.
- Consume and accept in the same cycle: back-to-back with no bubble, 1 instruction per cycle sustained.
- flush: next edge out_valid = 0. A simultaneous accept is dropped, and flush overrides both hold and load.
- reset has priority over flush, and reset during a stall discards the slot.

## Structure
- Shared package alu_pkg holds:
  - the Operation opcode constants/enum (shared with the ALU);
  - the alu_op encoding;
  - the funct3 constants.
- Sub-module alu_op_decode: purely combinational (alu_op, funct3, funct7_b5) → (Operation, illegal, shamt_sel).
- The stage instantiates alu_op_decode and adds the operand muxes and the slot register.

## Test plan
- Reset: assert reset 2 cycles with in_valid=1 → out_valid=0, Operation=0000, SrcA=0; in_ready=1 after release.
- R-type SUB: alu_op=10, funct3=000, funct7_b5=1, rs1=7, rs2=9, out_ready=1 → next cycle Operation=0101, SrcA=7, SrcB=9, out_valid=1.
- I-type shift:
  - SRAI: alu_op=11, funct3=101, funct7_b5=1, imm=0x405 → Operation=1110, SrcB=5.
  - ADDI: alu_op=11, funct3=000, funct7_b5=1 → Operation=0100.
- Backpressure: 3 back-to-back instructions, out_ready low for 2 cycles after the first → outputs stable, in_ready=0, no loss or duplication, order preserved.
- Flush: flush with in_valid=1 and in_ready=1 → out_valid=0 next cycle, accepted input discarded.
- Illegal: alu_op=10, funct3=011 → illegal_op=1, Operation=0000, out_valid=1. Also BLTU (alu_op=01, funct3=110) → illegal_op=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings: Operation opcodes, ID's ALUOp field and funct3 values.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_XOR = 4'b0010,
    OP_ADD = 4'b0100,
    OP_SUB = 4'b0101,
    OP_EQ  = 4'b1000,
    OP_LT  = 4'b1001,
    OP_SLL = 4'b1100,
    OP_SRL = 4'b1101,
    OP_SRA = 4'b1110
  } alu_opcode_e;

  typedef enum logic [1:0] {
    ALUOP_MEM = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_I   = 2'b11
  } alu_op_e;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct3/funct7 -> ALU Operation translation.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic [3:0] operation,
  output logic       illegal,
  output logic       shamt_sel
);

  always_comb begin
    operation = OP_AND;
    illegal   = 1'b0;
    shamt_sel = 1'b0;
    case (alu_op)
      ALUOP_MEM: operation = OP_ADD;
      ALUOP_BR: begin
        // Branch unit handles BNE/BGE inversion, so pairs share one compare.
        case (funct3)
          F3_BEQ, F3_BNE: operation = OP_EQ;
          F3_BLT, F3_BGE: operation = OP_LT;
          default:        illegal   = 1'b1;
        endcase
      end
      default: begin
        shamt_sel = (alu_op == ALUOP_I) && (funct3 == F3_SLL || funct3 == F3_SRL);
        case (funct3)
          F3_ADD:  operation = (alu_op == ALUOP_R && funct7_b5) ? OP_SUB : OP_ADD;
          F3_SLL:  operation = OP_SLL;
          F3_SLT:  operation = OP_LT;
          F3_XOR:  operation = OP_XOR;
          F3_SRL:  operation = funct7_b5 ? OP_SRA : OP_SRL;
          F3_OR:   operation = OP_OR;
          F3_AND:  operation = OP_AND;
          default: illegal   = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Single-slot execute-entry register feeding the ALU: decode, operand select,
// valid/ready handshake with stall hold and flush.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    alu_op,
  input  logic [2:0]                    funct3,
  input  logic                          funct7_b5,
  input  logic                          alu_src_a,
  input  logic                          alu_src_b,
  input  logic [DATA_WIDTH-1:0]         rs1_data,
  input  logic [DATA_WIDTH-1:0]         rs2_data,
  input  logic [DATA_WIDTH-1:0]         pc,
  input  logic [DATA_WIDTH-1:0]         imm,
  input  logic [REG_ADDR_W-1:0]         rd_in,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [DATA_WIDTH-1:0]  SrcA,
  output logic signed [DATA_WIDTH-1:0]  SrcB,
  output logic [OPCODE_LENGTH-1:0]      Operation,
  output logic [REG_ADDR_W-1:0]         rd_out,
  output logic                          illegal_op
);

  logic [3:0] dec_op;
  logic       dec_illegal, dec_shamt;

  alu_op_decode u_dec (
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7_b5 (funct7_b5),
    .operation (dec_op),
    .illegal   (dec_illegal),
    .shamt_sel (dec_shamt)
  );

  logic                     valid_q, valid_d;
  logic [DATA_WIDTH-1:0]    src_a_q, src_a_d, src_b_q, src_b_d;
  logic [OPCODE_LENGTH-1:0] op_q, op_d;
  logic [REG_ADDR_W-1:0]    rd_q, rd_d;
  logic                     ill_q, ill_d;
  logic                     accept;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    src_a_d = src_a_q;
    src_b_d = src_b_q;
    op_d    = op_q;
    rd_d    = rd_q;
    ill_d   = ill_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      src_a_d = alu_src_a ? pc : rs1_data;
      // I-type shifts take the shift amount from imm[4:0] only.
      src_b_d = dec_shamt ? {{(DATA_WIDTH-5){1'b0}}, imm[4:0]}
                          : (alu_src_b ? imm : rs2_data);
      op_d    = OPCODE_LENGTH'(dec_op);
      rd_d    = rd_in;
      ill_d   = dec_illegal;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      src_a_q <= '0;
      src_b_q <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid  = valid_q;
  assign SrcA       = src_a_q;
  assign SrcB       = src_b_q;
  assign Operation  = op_q;
  assign rd_out     = rd_q;
  assign illegal_op = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a scoreboard of accepted instructions.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, funct7_b5, alu_src_a, alu_src_b;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data, pc, imm;
  logic [4:0]  rd_in, rd_out;
  logic        flush, out_valid, out_ready, illegal_op;
  logic signed [31:0] SrcA, SrcB;
  logic [3:0]  Operation;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  op;
    logic        ill;
    logic [31:0] a, b;
    logic [4:0]  rd;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7_b5(funct7_b5),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc), .imm(imm),
    .rd_in(rd_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .rd_out(rd_out),
    .illegal_op(illegal_op)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode written straight from the opcode table.
  function automatic exp_t model();
    exp_t e;
    e.ill = 1'b0;
    e.op  = 4'b0000;
    e.a   = alu_src_a ? pc : rs1_data;
    e.b   = alu_src_b ? imm : rs2_data;
    e.rd  = rd_in;
    if (alu_op == 2'b00) e.op = 4'b0100;
    else if (alu_op == 2'b01) begin
      if (funct3 == 3'd0 || funct3 == 3'd1)      e.op = 4'b1000;
      else if (funct3 == 3'd4 || funct3 == 3'd5) e.op = 4'b1001;
      else e.ill = 1'b1;
    end else begin
      case (funct3)
        3'd0: e.op = (alu_op == 2'b10 && funct7_b5) ? 4'b0101 : 4'b0100;
        3'd1: e.op = 4'b1100;
        3'd2: e.op = 4'b1001;
        3'd3: e.ill = 1'b1;
        3'd4: e.op = 4'b0010;
        3'd5: e.op = funct7_b5 ? 4'b1110 : 4'b1101;
        3'd6: e.op = 4'b0001;
        default: e.op = 4'b0000;
      endcase
      if (alu_op == 2'b11 && (funct3 == 3'd1 || funct3 == 3'd5)) e.b = {27'd0, imm[4:0]};
    end
    return e;
  endfunction

  // Scoreboard: compare on consume, record on accept.
  always @(negedge clk) begin
    if (reset) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_unexpected_out", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_op", Operation, e.op);
          chk("sb_ill", illegal_op, e.ill);
          chk("sb_srca", SrcA, e.a);
          chk("sb_srcb", SrcB, e.b);
          chk("sb_rd", rd_out, e.rd);
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(model());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                       input logic sa, input logic sb_sel, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] p, input logic [31:0] im,
                       input logic [4:0] rd);
    in_valid = 1'b1; alu_op = aop; funct3 = f3; funct7_b5 = f7;
    alu_src_a = sa; alu_src_b = sb_sel; rs1_data = r1; rs2_data = r2;
    pc = p; imm = im; rd_in = rd;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(2'b10, 3'd0, 1'b0, 1'b0, 1'b0, 32'd11, 32'd22, 32'h40, 32'h8, 5'd9);

    // Reset held two cycles with a valid instruction present
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_op", Operation, 0);
    chk("rst_srca", SrcA, 0);
    chk("rst_inready", in_ready, 1);
    reset = 1'b0; in_valid = 1'b0;
    tick();
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_inready", in_ready, 1);

    // R-type SUB
    drive(2'b10, 3'd0, 1'b1, 1'b0, 1'b0, 32'd7, 32'd9, 32'h100, 32'h0, 5'd4);
    tick();
    chk("sub_op", Operation, 4'b0101);
    chk("sub_srca", SrcA, 7);
    chk("sub_srcb", SrcB, 9);
    chk("sub_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 0);
    chk("drain_hold_srca", SrcA, 7);

    // SRAI then ADDI back to back
    drive(2'b11, 3'd5, 1'b1, 1'b0, 1'b1, 32'd1, 32'd2, 32'h0, 32'h405, 5'd5);
    tick();
    chk("srai_op", Operation, 4'b1110);
    chk("srai_srcb", SrcB, 5);
    drive(2'b11, 3'd0, 1'b1, 1'b1, 1'b1, 32'd1, 32'd2, 32'h200, 32'h123, 5'd6);
    tick();
    chk("addi_op", Operation, 4'b0100);
    chk("addi_srca_pc", SrcA, 32'h200);
    chk("addi_srcb", SrcB, 32'h123);

    // Backpressure: I1 stalls two cycles while I2 waits
    drive(2'b10, 3'd0, 1'b0, 1'b0, 1'b0, 32'd100, 32'd23, 32'h0, 32'h0, 5'd1);
    tick();
    out_ready = 1'b0;
    drive(2'b10, 3'd4, 1'b0, 1'b1, 1'b0, 32'hF0, 32'h0F, 32'h1000, 32'h0, 5'd2);
    #1;
    chk("stall_inready", in_ready, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_srca", SrcA, 100);
      chk("stall_srcb", SrcB, 23);
      chk("stall_op", Operation, 4'b0100);
      chk("stall_rd", rd_out, 1);
      chk("stall_inready2", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_i2_srca", SrcA, 32'h1000);
    chk("bp_i2_op", Operation, 4'b0010);
    drive(2'b01, 3'd1, 1'b0, 1'b0, 1'b0, 32'd3, 32'd3, 32'h0, 32'h0, 5'd3);
    tick();
    chk("bp_i3_op", Operation, 4'b1000);
    chk("bp_i3_rd", rd_out, 3);
    in_valid = 1'b0;
    tick();
    chk("bp_drain", out_valid, 0);

    // Flush drops a simultaneous accept
    drive(2'b00, 3'd2, 1'b0, 1'b0, 1'b1, 32'd5, 32'd6, 32'h0, 32'h10, 5'd7);
    flush = 1'b1;
    #1;
    chk("flush_inready", in_ready, 1);
    tick();
    chk("flush_valid", out_valid, 0);
    flush = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("load_after_flush", out_valid, 1);
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    chk("flush_stalled", out_valid, 0);
    flush = 1'b0; out_ready = 1'b1;

    // Illegal decodes still flow through the slot
    drive(2'b10, 3'd3, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2, 32'h0, 32'h0, 5'd8);
    tick();
    chk("sltu_ill", illegal_op, 1);
    chk("sltu_op", Operation, 0);
    chk("sltu_valid", out_valid, 1);
    drive(2'b01, 3'd6, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2, 32'h0, 32'h0, 5'd9);
    tick();
    chk("bltu_ill", illegal_op, 1);
    drive(2'b11, 3'd1, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2, 32'h0, 32'hFFFF_FFE3, 5'd10);
    tick();
    chk("slli_ill", illegal_op, 0);
    chk("slli_srcb", SrcB, 32'h3);

    // Reset during a stall discards the slot
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk("pre_rst_stall", out_valid, 1);
    reset = 1'b1;
    tick();
    chk("rst_stall_valid", out_valid, 0);
    chk("rst_stall_srca", SrcA, 0);
    reset = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
